// File: rtl/subsample_8x8_avg.sv
// subsample_8x8_avg
// Chroma downsampler: consumes one 8x8 block as a raster-order pixel stream
// and produces a 4x4 block where each entry is the mean of one 2x2 input quad.
// The horizontal pair is summed on even rows and parked in psum; the odd row
// completes the quad, so only one row of partial sums is ever held.

module subsample_8x8_avg #(
    parameter int PIX_W = 8,
    parameter int ROUND = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         valid_in,
    output logic                         ready_in,
    input  logic [PIX_W-1:0]             pixel_in,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic [3:0][3:0][PIX_W-1:0]   block_out
);

    localparam int SW = PIX_W + 2;
    localparam logic [SW-1:0] RND = (ROUND != 0) ? SW'(2) : '0;

    logic [5:0]                 pix_cnt;
    logic [PIX_W-1:0]           h_reg;
    logic [SW-1:0]              psum [4];
    logic [3:0][3:0][PIX_W-1:0] work;
    logic [3:0][3:0][PIX_W-1:0] final_block;

    logic [2:0]       row;
    logic [2:0]       col;
    logic [1:0]       quad_row;
    logic [1:0]       quad_col;
    logic             last_pix;
    logic             accept;
    logic             complete;
    logic [SW-1:0]    quad_sum;
    logic [PIX_W-1:0] quad_avg;

    assign row      = pix_cnt[5:3];
    assign col      = pix_cnt[2:0];
    assign quad_row = row[2:1];
    assign quad_col = col[2:1];
    assign last_pix = (pix_cnt == 6'd63);

    // Only the final pixel can stall: it would overwrite a block still waiting
    // for the consumer. Earlier pixels land in work, which is separate.
    assign ready_in = !(last_pix && valid_out && !ready_out);
    assign accept   = valid_in && ready_in && !clear;
    assign complete = accept && last_pix;

    // Four 8-bit pixels plus the rounding constant fit in PIX_W+2 bits.
    assign quad_sum = psum[quad_col] + SW'(h_reg) + SW'(pixel_in) + RND;
    assign quad_avg = quad_sum[SW-1:2];

    // The last quad is still being computed when the block completes, so
    // splice the fresh average into the copy of work that gets published.
    always_comb begin
        final_block       = work;
        final_block[3][3] = quad_avg;
    end

    // Raster position within the block; clear restarts the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt <= '0;
        end else if (clear) begin
            pix_cnt <= '0;
        end else if (accept) begin
            pix_cnt <= pix_cnt + 6'd1;
        end
    end

    // Horizontal pair, vertical accumulation and per-quad result storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_reg <= '0;
            for (int i = 0; i < 4; i++) begin
                psum[i] <= '0;
            end
            work <= '0;
        end else if (accept) begin
            if (!col[0]) begin
                h_reg <= pixel_in;
            end else if (!row[0]) begin
                psum[quad_col] <= SW'(h_reg) + SW'(pixel_in);
            end else begin
                work[quad_row][quad_col] <= quad_avg;
            end
        end
    end

    // Output register: a completion always loads, otherwise a handshake frees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            block_out <= '0;
        end else if (complete) begin
            valid_out <= 1'b1;
            block_out <= final_block;
        end else if (ready_out) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_subsample_8x8_avg.sv
// tb_subsample_8x8_avg
// Drives 8x8 blocks into a rounding and a truncating instance side by side,
// computes the expected 4x4 quad means from the accepted pixels and compares
// each delivered block against a queue of expectations.

module tb_subsample_8x8_avg;

    typedef logic [3:0][3:0][7:0] blk_t;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       valid_in;
    logic [7:0] pixel_in;
    logic       ready_out;
    logic       ready_in;
    logic       valid_out;
    blk_t       block_out;
    logic       ready_in_t;
    logic       valid_out_t;
    blk_t       block_out_t;

    int checks = 0;
    int errors = 0;

    blk_t exp_r[$];
    blk_t exp_t[$];
    logic [7:0] mpix [64];
    int mcount = 0;

    subsample_8x8_avg #(.PIX_W(8), .ROUND(1)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in),
        .ready_in(ready_in), .pixel_in(pixel_in), .valid_out(valid_out),
        .ready_out(ready_out), .block_out(block_out)
    );

    subsample_8x8_avg #(.PIX_W(8), .ROUND(0)) dut_trunc (
        .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in),
        .ready_in(ready_in_t), .pixel_in(pixel_in), .valid_out(valid_out_t),
        .ready_out(ready_out), .block_out(block_out_t)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: collect accepted pixels; on the 64th, average every 2x2 quad.
    task automatic modelAccept(input logic [7:0] p);
        blk_t br;
        blk_t bt;
        int   s;
        mpix[mcount] = p;
        mcount++;
        if (mcount == 64) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    s = int'(mpix[16*i + 2*j]) + int'(mpix[16*i + 2*j + 1])
                      + int'(mpix[16*i + 8 + 2*j]) + int'(mpix[16*i + 8 + 2*j + 1]);
                    br[i][j] = 8'((s + 2) / 4);
                    bt[i][j] = 8'(s / 4);
                end
            end
            exp_r.push_back(br);
            exp_t.push_back(bt);
            mcount = 0;
        end
    endtask

    function automatic logic [7:0] pixelFor(input int kind, input int idx);
        int r;
        int c;
        r = idx / 8;
        c = idx % 8;
        case (kind)
            0:       return 8'(8 * r + c);
            1:       return 8'd255;
            2:       return 8'd0;
            3:       return 8'((r % 2) * 2 + (c % 2) + 1);
            4:       return ((r % 2) == 1 && (c % 2) == 1) ? 8'd1 : 8'd0;
            5:       return ((r % 2) == 1 && (c % 2) == 1) ? 8'd0 : 8'd1;
            default: return 8'($urandom_range(255));
        endcase
    endfunction

    // Present one pixel until the DUT takes it; reports cycles spent stalled.
    task automatic applyStimulus(input logic [7:0] p, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        @(negedge clk);
        valid_in = 1'b1;
        pixel_in = p;
        while (!ok && waited <= 200) begin
            #2;
            ok = ready_in;
            @(posedge clk);
            if (!ok) begin
                waited++;
                @(negedge clk);
            end
        end
        if (ok) begin
            modelAccept(p);
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual=stalled required=accepted");
        end
        #1 valid_in = 1'b0;
    endtask

    task automatic sendPixels(input int kind, input int first, input int count, input int bubblePct, output int totalWait);
        int w;
        totalWait = 0;
        for (int idx = first; idx < first + count; idx++) begin
            while (bubblePct > 0 && $urandom_range(99) < bubblePct) @(negedge clk);
            applyStimulus(pixelFor(kind, idx), w);
            totalWait += w;
        end
    endtask

    task automatic sendBlock(input int kind, input int bubblePct);
        int w;
        sendPixels(kind, 0, 64, bubblePct, w);
    endtask

    // Monitor: every accepted output block is popped against the scoreboard.
    initial begin
        blk_t er;
        blk_t et;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && ready_out && exp_r.size() > 0) begin
                checkOutput("valid_latency", 128'(valid_out), 128'(1));
            end
            if (valid_out && ready_out) begin
                if (exp_r.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_block actual=%h required=none", block_out);
                end else begin
                    er = exp_r.pop_front();
                    et = exp_t.pop_front();
                    checkOutput("block_round", block_out, er);
                    checkOutput("block_trunc", block_out_t, et);
                    checkOutput("valid_trunc", 128'(valid_out_t), 128'(1));
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        blk_t blkA;
        blk_t blkB;
        int   w;
        int   drain;

        rst_n     = 1'b0;
        clear     = 1'b0;
        valid_in  = 1'b0;
        pixel_in  = '0;
        ready_out = 1'b1;
        #1;
        checkOutput("reset_valid_out", 128'(valid_out), 128'(0));
        checkOutput("reset_block_out", block_out, 128'(0));
        checkOutput("reset_ready_in", 128'(ready_in), 128'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] ramp, constants and quad patterns");
        sendBlock(0, 0);
        sendBlock(1, 0);
        sendBlock(2, 0);
        sendBlock(3, 0);
        sendBlock(4, 0);
        sendBlock(5, 0);
        sendBlock(6, 0);
        repeat (3) @(negedge clk);

        $display("[TB] backpressure");
        ready_out = 1'b0;
        sendBlock(6, 0);
        repeat (3) @(negedge clk);
        blkA = exp_r[0];
        #2;
        checkOutput("bp_valid_held", 128'(valid_out), 128'(1));
        checkOutput("bp_block_a", block_out, blkA);
        sendPixels(0, 0, 63, 0, w);
        checkOutput("bp_no_stall_0_62", 128'(w), 128'(0));
        @(negedge clk);
        valid_in = 1'b1;
        pixel_in = pixelFor(0, 63);
        repeat (3) begin
            #2;
            checkOutput("bp_stall_ready_in", 128'(ready_in), 128'(0));
            checkOutput("bp_hold_block_a", block_out, blkA);
            @(negedge clk);
        end
        ready_out = 1'b1;
        #2;
        checkOutput("bp_release_ready_in", 128'(ready_in), 128'(1));
        checkOutput("bp_release_valid", 128'(valid_out), 128'(1));
        @(posedge clk);
        modelAccept(pixelFor(0, 63));
        #1 valid_in = 1'b0;
        @(negedge clk);
        #2;
        blkB = exp_r[0];
        checkOutput("b2b_valid", 128'(valid_out), 128'(1));
        checkOutput("b2b_block_b", block_out, blkB);
        repeat (3) @(negedge clk);

        $display("[TB] ramp with random bubbles");
        sendBlock(0, 50);
        sendBlock(6, 50);
        repeat (3) @(negedge clk);

        $display("[TB] clear mid-block");
        sendPixels(0, 0, 20, 0, w);
        @(negedge clk);
        clear    = 1'b1;
        valid_in = 1'b1;
        pixel_in = 8'd99;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        valid_in = 1'b0;
        mcount   = 0;
        sendBlock(0, 0);
        repeat (3) @(negedge clk);

        $display("[TB] async reset with pending output");
        ready_out = 1'b0;
        sendBlock(6, 0);
        repeat (2) @(negedge clk);
        #2;
        checkOutput("pre_reset_valid", 128'(valid_out), 128'(1));
        sendPixels(6, 0, 10, 0, w);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_valid_out", 128'(valid_out), 128'(0));
        checkOutput("async_block_out", block_out, 128'(0));
        checkOutput("async_block_trunc", block_out_t, 128'(0));
        checkOutput("async_ready_in", 128'(ready_in), 128'(1));
        exp_r.delete();
        exp_t.delete();
        mcount = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        ready_out = 1'b1;
        sendBlock(0, 0);

        drain = 0;
        while (exp_r.size() > 0 && drain < 50) begin
            @(negedge clk);
            drain++;
        end
        repeat (2) @(negedge clk);
        checkOutput("queue_drained", 128'(exp_r.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/subsample_8x8_avg.md
Name: subsample_8x8_avg

Overview:
- Chroma downsampler: the inverse direction of the 4x4-to-8x8 bilinear supersampler.
- Accepts one 8x8 block as a raster-order pixel stream, one pixel per accepted beat.
- Produces a 4x4 block where each output is the rounded mean of the corresponding 2x2 input quad.
- Sits on the encode/test-vector path, feeding 4x4 chroma blocks to consumers that use the supersampler's block interface.

Parameters:
- PIX_W, 8, pixel bit width for input and output.
- ROUND, 1, 1 = round-half-up (sum+2)>>2; 0 = truncate sum>>2.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort; discards the partial block.
- valid_in  input  1  pixel_in valid.
- ready_in  output  1  block can accept pixel_in this cycle.
- pixel_in  input  PIX_W  input pixel, raster order (row 0 col 0..7, row 1, ...).
- valid_out  output  1  block_out holds a complete 4x4 block.
- ready_out  input  1  consumer accepts block_out.
- block_out  output  [3:0][3:0][PIX_W-1:0]  registered 4x4 result, indexed [row][col].

Behaviour:
- Reset (rst_n low, async):
  - pix_cnt=0, h_reg=0, psum[0..3]=0, work array=0.
  - valid_out=0, block_out all 0.
  - ready_in is combinational and equals 1 after reset.
- Accept/transfer rules:
  - A pixel is accepted when valid_in && ready_in.
  - pix_cnt is 6 bits; row=pix_cnt[5:3], col=pix_cnt[2:0]. It increments on each accept and wraps 63->0.
  - ready_in = !(pix_cnt==63 && valid_out && !ready_out). Only the final pixel of a block can stall.
- Datapath on accept:
  - Even col: h_reg <= pixel_in.
  - Even row, odd col: psum[col>>1] <= h_reg + pixel_in (PIX_W+2 bits).
  - Odd row, odd col: q = psum[col>>1] + h_reg + pixel_in (+2 if ROUND), computed at PIX_W+2 bits with no overflow (max 4*255+2=1022).
  - Result r = q>>2 is written to work[row>>1][col>>1].
- Block completion (accept at pix_cnt==63):
  - block_out <= work with entry [3][3] replaced by the freshly computed r, all in the same cycle.
  - valid_out <= 1.
  - Latency: block_out is valid the cycle after the 64th accept.
- Output handshake:
  - valid_out stays high and block_out stays stable until ready_out.
  - valid_out && ready_out with no completion in the same cycle: valid_out <= 0; block_out retains its value.
  - Completion and ready_out in the same cycle: the new block loads and valid_out stays 1. This gives back-to-back blocks with no bubble.
  - Input pixels 0..62 of the next block are accepted while the previous block waits on valid_out. Only pixel 63 stalls.
- Boundaries and resets:
  - clear=1: pix_cnt <= 0, h_reg and psum unaffected (they are overwritten before use). The beat presented in the same cycle is dropped, even if valid_in && ready_in.
  - clear does not affect valid_out or block_out; a pending output block remains deliverable.
  - Async reset mid-block: the partial block and any pending output are lost; valid_out drops immediately.
  - valid_in low: no state change. Bubbles anywhere in the stream are legal.

Test Plan:
- Ascending ramp, pixel(r,c)=8r+c, ready_out=1, ROUND=1 -> one valid_out pulse the cycle after the 64th accept. block_out[i][j]=16i+2j+5, e.g. [0][0]=5, [0][1]=7, [3][3]=59. ROUND=0 -> 16i+2j+4.
- All pixels 255, then all 0 -> first block all 255 (no overflow), second block all 0.
- Quad mix 1,2,3,4 in every 2x2 -> ROUND=1 gives 3 (12/4); pattern 0,0,0,1 -> ROUND=1 gives 0 ((1+2)>>2=0); pattern 1,1,1,0 -> 1 (5>>2).
- Backpressure: ready_out=0 after block A, stream block B -> pixels 0..62 accepted, ready_in=0 at pix_cnt=63, block_out holds A. Raise ready_out -> B's last pixel accepted the same cycle and block_out=B the next cycle, with valid_out continuously 1.
- Random valid_in bubbles (50%) over ramp data -> results identical to the first test.
- clear asserted after 20 pixels, then a full ramp block -> output equals the ramp result. Separately, async rst_n pulse while valid_out=1 -> valid_out=0 and block_out=0 immediately.
